autocorrelator: RTL

Upstream stage of the LPC Durbin recursion block. Accumulates the integer autocorrelation r[k] = sum x[n]*x[n-k], for lags k = 0..ORDER, over one block of windowed signed samples. Each lag is converted to IEEE-754 single precision. Results stream out serially, highest lag first, as one word per cycle for 13 consecutive cycles. This matches the Durbin block's shift-in load, which leaves lag 0 in acf[0].

---
 rtl/autocorrelator.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/autocorrelator.sv
// Block autocorrelation r[k] = sum x[n]*x[n-k], k = 0..ORDER, streamed out
// as IEEE-754 singles, highest lag first, through a two-stage float converter.
module autocorrelator #(
    parameter int ORDER      = 12,
    parameter int BLOCK_SIZE = 4096,
    parameter int SAMPLE_W   = 16,
    parameter int ACC_W      = 48
) (
    input  logic                       iClock,
    input  logic                       iReset,
    input  logic                       iEnable,
    input  logic signed [SAMPLE_W-1:0] iSample,
    input  logic                       iValid,
    output logic                       oReady,
    output logic [31:0]                oACF,
    output logic                       oValid,
    output logic                       oDone
);

    localparam int CNT_W = $clog2(BLOCK_SIZE + 1);
    localparam int LAG_W = $clog2(ORDER + 1);
    localparam int POS_W = $clog2(ACC_W);
    localparam int PROD_W = 2 * SAMPLE_W;
    localparam logic [POS_W-1:0] TOP_POS = POS_W'(ACC_W - 1);

    typedef enum logic [1:0] {
        S_ACCUM   = 2'd0,
        S_CONVERT = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t                     r_state;
    logic                       r_ready;
    logic [CNT_W-1:0]           r_cnt;
    logic [LAG_W-1:0]           r_lag;
    logic signed [ACC_W-1:0]    r_acc [0:ORDER];
    logic signed [SAMPLE_W-1:0] r_dly [1:ORDER];

    logic                       r_s0_val;
    logic                       r_s0_last;
    logic signed [ACC_W-1:0]    r_s0_acc;

    logic                       r_s1_val;
    logic                       r_s1_last;
    logic                       r_s1_sign;
    logic                       r_s1_zero;
    logic [ACC_W-1:0]           r_s1_mag;
    logic [POS_W-1:0]           r_s1_pos;

    logic [31:0]                r_acf;
    logic                       r_valid;
    logic                       r_done;

    logic signed [SAMPLE_W-1:0] w_tap  [0:ORDER];
    logic signed [PROD_W-1:0]   w_prod [0:ORDER];

    logic                       w_s1_sign;
    logic                       w_s1_zero;
    logic [ACC_W-1:0]           w_s1_mag;
    logic [POS_W-1:0]           w_s1_pos;

    logic [POS_W-1:0]           w_shamt;
    logic [ACC_W-1:0]           w_norm;
    logic [22:0]                w_mant;
    logic                       w_guard;
    logic                       w_sticky;
    logic                       w_round_up;
    logic [24:0]                w_sum;
    logic [7:0]                 w_exp;
    logic [22:0]                w_frac;
    logic [31:0]                w_packed;

    assign oReady = r_ready;
    assign oACF   = r_acf;
    assign oValid = r_valid;
    assign oDone  = r_done;

    // Tap 0 is the sample being accepted; tap k is the sample k earlier.
    always_comb begin
        for (int k = 0; k <= ORDER; k++) begin
            w_tap[k]  = (k == 0) ? iSample : r_dly[k];
            w_prod[k] = iSample * w_tap[k];
        end
    end

    always_comb begin
        w_s1_sign = r_s0_acc[ACC_W-1];
        w_s1_zero = (r_s0_acc == '0);
        w_s1_mag  = w_s1_sign ? $unsigned(-r_s0_acc) : $unsigned(r_s0_acc);
        w_s1_pos  = '0;
        for (int i = 0; i < ACC_W; i++) begin
            if (w_s1_mag[i]) w_s1_pos = POS_W'(i);
        end
    end

    // Leading one moved to the MSB; the 23 bits below it are the mantissa.
    always_comb begin
        w_shamt    = TOP_POS - r_s1_pos;
        w_norm     = r_s1_mag << w_shamt;
        w_mant     = w_norm[ACC_W-2 -: 23];
        w_guard    = w_norm[ACC_W-25];
        w_sticky   = |w_norm[ACC_W-26:0];
        w_round_up = w_guard && (w_sticky || w_mant[0]);
        w_sum      = {2'b01, w_mant} + 25'(w_round_up);
        w_exp      = 8'd127 + 8'(r_s1_pos) + 8'(w_sum[24]);
        w_frac     = w_sum[24] ? w_sum[23:1] : w_sum[22:0];
        w_packed   = r_s1_zero ? 32'h0 : {r_s1_sign, w_exp, w_frac};
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_state   <= S_ACCUM;
            r_ready   <= 1'b1;
            r_cnt     <= '0;
            r_lag     <= LAG_W'(ORDER);
            for (int k = 0; k <= ORDER; k++) r_acc[k] <= '0;
            for (int k = 1; k <= ORDER; k++) r_dly[k] <= '0;
            r_s0_val  <= 1'b0;
            r_s0_last <= 1'b0;
            r_s0_acc  <= '0;
            r_s1_val  <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_sign <= 1'b0;
            r_s1_zero <= 1'b1;
            r_s1_mag  <= '0;
            r_s1_pos  <= '0;
            r_acf     <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
        end else if (iEnable) begin
            r_s0_val  <= (r_state == S_CONVERT);
            r_s0_last <= (r_state == S_CONVERT) && (r_lag == '0);
            r_s0_acc  <= r_acc[r_lag];

            r_s1_val  <= r_s0_val;
            r_s1_last <= r_s0_last;
            r_s1_sign <= w_s1_sign;
            r_s1_zero <= w_s1_zero;
            r_s1_mag  <= w_s1_mag;
            r_s1_pos  <= w_s1_pos;

            r_acf     <= r_s1_val ? w_packed : 32'h0;
            r_valid   <= r_s1_val;
            r_done    <= r_s1_val && r_s1_last;

            case (r_state)
                S_ACCUM: begin
                    if (iValid) begin
                        for (int k = 0; k <= ORDER; k++) begin
                            r_acc[k] <= r_acc[k] + {{(ACC_W-PROD_W){w_prod[k][PROD_W-1]}}, w_prod[k]};
                        end
                        r_dly[1] <= iSample;
                        for (int k = 2; k <= ORDER; k++) r_dly[k] <= r_dly[k-1];
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(BLOCK_SIZE - 1)) begin
                            r_state <= S_CONVERT;
                            r_ready <= 1'b0;
                            r_lag   <= LAG_W'(ORDER);
                        end
                    end
                end
                S_CONVERT: begin
                    if (r_lag == '0) r_state <= S_DRAIN;
                    else             r_lag   <= r_lag - 1'b1;
                end
                S_DRAIN: begin
                    // Lag 0 has left the pipeline; start a fresh block.
                    if (r_done) begin
                        r_state <= S_ACCUM;
                        r_ready <= 1'b1;
                        r_cnt   <= '0;
                        for (int k = 0; k <= ORDER; k++) r_acc[k] <= '0;
                        for (int k = 1; k <= ORDER; k++) r_dly[k] <= '0;
                    end
                end
                default: r_state <= S_ACCUM;
            endcase
        end
    end

endmodule
